// File: rtl/i2c_master_controller.sv
// Queued single-byte I2C master: requests are buffered in a small FIFO and
// played out as complete frames, one bit per system clock. SCL is the
// inverted system clock during bit phases so data is stable at SCL rise.
//
// state  | meaning
// IDLE   | bus idle, SDA=1 SCL=1, pops next request when one is available
// START  | SDA low with SCL high (start condition)
// ADDR   | 7 address bits, MSB first
// RW     | read/write bit
// ACK1   | SDA released, slave address ACK sampled at the closing edge
// WDATA  | 8 write data bits, MSB first
// ACK2   | SDA released, slave data ACK sampled and ignored
// RDATA  | SDA released, 8 bits shifted in MSB first
// MNACK  | master NACK (SDA=1), read byte published
// STOP   | SCL high with SDA low; the following IDLE raises SDA
module i2c_master_controller #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       i2c_clock_in,
  input  logic       i2c_reset_in,
  input  logic       i2c_start,
  input  logic       rw_bit,
  input  logic [6:0] i2c_master_addr_wr,
  input  logic [7:0] i2c_master_data_wr,
  output logic [7:0] i2c_master_data_rd,
  output logic       fifo_full,
  output logic       ready_out,
  inout  wire        i2c_sda_inout,
  inout  wire        i2c_scl_inout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_RW, S_ACK1,
    S_WDATA, S_ACK2, S_RDATA, S_MNACK, S_STOP
  } state_t;

  state_t           state;
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_avail;
  logic             push;
  logic             pop;
  logic [15:0]      fifo_head;

  logic             rw_q;
  logic [7:0]       data_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic             sda_out;
  logic             sda_oe;
  logic             scl_en;
  logic             sda_in;

  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign pop       = (state == S_IDLE) && fifo_avail;
  // A pop in the same cycle frees a slot, so a push at full is still taken.
  assign push      = i2c_start && (!fifo_full || pop);
  assign fifo_head = fifo_mem[rd_ptr];

  assign i2c_scl_inout = scl_en ? ~i2c_clock_in : 1'b1;
  assign i2c_sda_inout = sda_oe ? sda_out : 1'bz;
  assign sda_in        = i2c_sda_inout;

  // Request storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge i2c_clock_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {rw_bit, i2c_master_addr_wr, i2c_master_data_wr};
    end
  end

  // FIFO pointers, occupancy and the registered non-empty flag seen by the FSM.
  // The flag lags occupancy by a cycle; it is only consulted in IDLE, which is
  // never entered within a cycle of a pop, so the lag cannot cause a false pop.
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_in) begin
    if (!i2c_reset_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      fifo_avail <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) begin
        fifo_cnt <= fifo_cnt + CNT_W'(1);
      end else if (!push && pop) begin
        fifo_cnt <= fifo_cnt - CNT_W'(1);
      end
      fifo_avail <= (fifo_cnt != '0);
    end
  end

  // Frame sequencer with registered bus outputs.
  always_ff @(posedge i2c_clock_in or negedge i2c_reset_in) begin
    if (!i2c_reset_in) begin
      state              <= S_IDLE;
      rw_q               <= 1'b0;
      data_q             <= 8'h00;
      shift_q            <= 8'h00;
      bit_cnt            <= 3'd0;
      sda_out            <= 1'b1;
      sda_oe             <= 1'b1;
      scl_en             <= 1'b0;
      ready_out          <= 1'b1;
      i2c_master_data_rd <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_avail) begin
            rw_q      <= fifo_head[15];
            data_q    <= fifo_head[7:0];
            shift_q   <= {fifo_head[14:8], 1'b0};
            sda_out   <= 1'b0;
            ready_out <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          sda_out <= shift_q[7];
          shift_q <= {shift_q[6:0], 1'b0};
          bit_cnt <= 3'd6;
          scl_en  <= 1'b1;
          state   <= S_ADDR;
        end
        S_ADDR: begin
          if (bit_cnt == 3'd0) begin
            sda_out <= rw_q;
            state   <= S_RW;
          end else begin
            sda_out <= shift_q[7];
            shift_q <= {shift_q[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        S_RW: begin
          sda_oe <= 1'b0;
          state  <= S_ACK1;
        end
        S_ACK1: begin
          bit_cnt <= 3'd7;
          if (sda_in) begin
            sda_oe  <= 1'b1;
            sda_out <= 1'b0;
            scl_en  <= 1'b0;
            state   <= S_STOP;
          end else if (rw_q) begin
            shift_q <= 8'h00;
            state   <= S_RDATA;
          end else begin
            sda_oe  <= 1'b1;
            sda_out <= data_q[7];
            shift_q <= {data_q[6:0], 1'b0};
            state   <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (bit_cnt == 3'd0) begin
            sda_oe <= 1'b0;
            state  <= S_ACK2;
          end else begin
            sda_out <= shift_q[7];
            shift_q <= {shift_q[6:0], 1'b0};
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        S_ACK2: begin
          sda_oe  <= 1'b1;
          sda_out <= 1'b0;
          scl_en  <= 1'b0;
          state   <= S_STOP;
        end
        S_RDATA: begin
          shift_q <= {shift_q[6:0], sda_in};
          if (bit_cnt == 3'd0) begin
            sda_oe  <= 1'b1;
            sda_out <= 1'b1;
            state   <= S_MNACK;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        S_MNACK: begin
          i2c_master_data_rd <= shift_q;
          sda_out            <= 1'b0;
          scl_en             <= 1'b0;
          state              <= S_STOP;
        end
        S_STOP: begin
          sda_out   <= 1'b1;
          ready_out <= 1'b1;
          bit_cnt   <= 3'd0;
          state     <= S_IDLE;
        end
        default: begin
          sda_oe    <= 1'b1;
          sda_out   <= 1'b1;
          scl_en    <= 1'b0;
          ready_out <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: a frame-position model predicts the bus
// waveform, FIFO state and read data every cycle; directed frames add
// literal expectations on whole SDA bit patterns and timing points.
module tb_i2c_master_controller;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] data_rd;
  logic       full;
  logic       ready;
  wire        sda_line;
  wire        scl_line;
  logic       slave_oe;
  logic       slave_val;

  assign sda_line = slave_oe ? slave_val : 1'bz;

  i2c_master_controller #(.FIFO_DEPTH(DEPTH)) dut (
    .i2c_clock_in       (clk),
    .i2c_reset_in       (rst_n),
    .i2c_start          (start),
    .rw_bit             (rw),
    .i2c_master_addr_wr (addr),
    .i2c_master_data_wr (wdata),
    .i2c_master_data_rd (data_rd),
    .fifo_full          (full),
    .ready_out          (ready),
    .i2c_sda_inout      (sda_line),
    .i2c_scl_inout      (scl_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int falls  = 0;

  // slave behaviour for the current frame
  logic       slave_nack = 1'b0;
  logic [7:0] slave_rd   = 8'h00;

  // model: queue of requests, position in frame (-1 = idle), current request
  logic [15:0] mq[$];
  int          pos    = -1;
  logic [15:0] cur    = 16'h0;
  int          cnt_a1 = 0;
  int          cnt_a2 = 0;
  logic [7:0]  exp_rd = 8'h00;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame positions: 0 START, 1-7 address, 8 rw, 9 ack1, 10-17 data,
  // 18 ack2/mnack, 19 STOP. A NACK jumps from 9 to 19. A request starts
  // two edges after it is in the queue, once the bus is idle.
  task automatic model_step();
    logic do_pop;
    if (!rst_n) begin
      mq.delete();
      pos    = -1;
      cnt_a1 = 0;
      cnt_a2 = 0;
      exp_rd = 8'h00;
      return;
    end
    do_pop = (pos == -1) && (cnt_a2 > 0) && (mq.size() > 0);
    if (pos == -1) pos = do_pop ? 0 : -1;
    else if (pos == 19) pos = -1;
    else if (pos == 9 && slave_nack) pos = 19;
    else begin
      if (pos == 18 && cur[15]) exp_rd = slave_rd;
      pos++;
    end
    if (do_pop) cur = mq.pop_front();
    if (start && mq.size() < DEPTH) mq.push_back({rw, addr, wdata});
    cnt_a2 = cnt_a1;
    cnt_a1 = mq.size();
  endtask

  function automatic logic exp_sda(input int p);
    if (p < 0)   return 1'b1;
    if (p == 0)  return 1'b0;
    if (p <= 7)  return cur[15-p];
    if (p == 8)  return cur[15];
    if (p == 9)  return slave_nack;
    if (p <= 17) return cur[15] ? slave_rd[17-p] : cur[17-p];
    if (p == 18) return cur[15] ? 1'b1 : 1'b0;
    return 1'b0;
  endfunction

  // single compare process: model update, slave drive, per-cycle checks
  initial begin
    logic prev_ready;
    prev_ready = 1'b1;
    slave_oe   = 1'b0;
    slave_val  = 1'b1;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      slave_oe  = 1'b0;
      slave_val = 1'b1;
      if (pos == 9) begin
        slave_oe = 1'b1; slave_val = slave_nack;
      end else if (pos >= 10 && pos <= 17 && cur[15]) begin
        slave_oe = 1'b1; slave_val = slave_rd[17-pos];
      end else if (pos == 18 && !cur[15]) begin
        slave_oe = 1'b1; slave_val = 1'b0;
      end
      #1;
      chk("scl_clk_high", {19'b0, scl_line}, {19'b0, !(pos >= 1 && pos <= 18)});
      @(negedge clk);
      chk("scl_clk_low", {19'b0, scl_line}, 20'd1);
      chk("sda", {19'b0, sda_line}, {19'b0, exp_sda(pos)});
      chk("ready_out", {19'b0, ready}, {19'b0, pos == -1});
      chk("fifo_full", {19'b0, full}, {19'b0, mq.size() == DEPTH});
      chk("data_rd", {12'b0, data_rd}, {12'b0, exp_rd});
      if (prev_ready && !ready) falls++;
      prev_ready = ready;
    end
  end

  task automatic push_req(input logic r, input logic [6:0] a, input logic [7:0] d);
    start = 1'b1; rw = r; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic capture(input int n, output logic [19:0] pat);
    pat = '0;
    for (int i = 0; i < n; i++) begin
      pat = {pat[18:0], sda_line};
      @(negedge clk);
    end
  endtask

  initial begin
    logic [19:0] pat;
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = 7'h0; wdata = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_sda", {19'b0, sda_line}, 20'd1);
    chk("rst_scl", {19'b0, scl_line}, 20'd1);
    chk("rst_ready", {19'b0, ready}, 20'd1);
    chk("rst_full", {19'b0, full}, 20'd0);
    chk("rst_data_rd", {12'b0, data_rd}, 20'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // write 0x55 / 0xD3 with ACK
    slave_nack = 1'b0;
    push_req(1'b0, 7'h55, 8'hD3);
    chk("wr_idle_n1", {19'b0, ready}, 20'd1);
    @(negedge clk);
    chk("wr_idle_n2", {19'b0, ready}, 20'd1);
    @(negedge clk);
    chk("wr_start_latency", {19'b0, ready}, 20'd0);
    capture(20, pat);
    chk("wr_pattern", pat, {1'b0, 7'h55, 1'b0, 1'b0, 8'hD3, 1'b0, 1'b0});
    chk("wr_end_sda", {19'b0, sda_line}, 20'd1);
    chk("wr_end_ready", {19'b0, ready}, 20'd1);
    chk("wr_data_rd", {12'b0, data_rd}, 20'h00);

    // read 0x59, slave returns 0x99
    @(negedge clk);
    slave_rd = 8'h99;
    push_req(1'b1, 7'h59, 8'h00);
    repeat (2) @(negedge clk);
    capture(20, pat);
    chk("rd_pattern", pat, {1'b0, 7'h59, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0});
    chk("rd_data_rd", {12'b0, data_rd}, 20'h99);

    // address NACK
    @(negedge clk);
    slave_nack = 1'b1;
    push_req(1'b0, 7'h2A, 8'hFF);
    repeat (2) @(negedge clk);
    capture(11, pat);
    chk("nack_pattern", pat, {9'b0, 1'b0, 7'h2A, 1'b0, 1'b1, 1'b0});
    chk("nack_ready", {19'b0, ready}, 20'd1);
    chk("nack_data_rd_hold", {12'b0, data_rd}, 20'h99);
    slave_nack = 1'b0;

    // FIFO fill while a frame runs; overflow dropped, push+pop at full kept
    repeat (3) @(negedge clk);
    falls = 0;
    push_req(1'b0, 7'h40, 8'h01);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 28; i++) begin
      if (i == 7)  chk("fifo_not_full_7", {19'b0, full}, 20'd0);
      if (i == 8)  chk("fifo_full_8", {19'b0, full}, 20'd1);
      if (i == 20) chk("fifo_idle_gap", {18'b0, ready, full}, 20'd3);
      if (i == 21) chk("fifo_pushpop_full", {18'b0, ready, full}, 20'd1);
      start = 1'b1; rw = 1'b0;
      addr  = 7'(7'h20 + i);
      wdata = 8'(8'h10 + i);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (200) @(negedge clk);
    chk("fifo_frames", falls, 20'd10);
    chk("fifo_drained", {18'b0, ready, full}, 20'd2);

    // reset during WDATA aborts and discards the queue
    start = 1'b1; rw = 1'b0; addr = 7'h33; wdata = 8'hA5;
    @(negedge clk);
    addr = 7'h34; wdata = 8'h5A;
    @(negedge clk);
    addr = 7'h35; wdata = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_busy", {19'b0, ready}, 20'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_sda", {19'b0, sda_line}, 20'd1);
    chk("abort_scl", {19'b0, scl_line}, 20'd1);
    chk("abort_ready", {19'b0, ready}, 20'd1);
    chk("abort_full", {19'b0, full}, 20'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    falls = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_frames", falls, 20'd0);
    chk("abort_idle", {19'b0, ready}, 20'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
